// File: rtl/laser_tracker_pkg.sv
// Shared types and helpers for the laser tracker: coordinate widths, xy packing,
// tracking states and the per-axis distance helper.
package laser_tracker_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned XY_W    = 2 * COORD_W;
  localparam int unsigned ERR_W   = COORD_W + 1;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_COAST   = 2'd3
  } track_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } xy_t;

  function automatic logic [XY_W-1:0] xy_pack(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y);
    xy_t v;
    v.x = x;
    v.y = y;
    return v;
  endfunction

  function automatic xy_t xy_unpack(input logic [XY_W-1:0] xy);
    return xy_t'(xy);
  endfunction

  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage

// File: rtl/laser_avg_window.sv
// One axis of the sliding position window: shift register, running sum and fill
// count; clear empties the window so the next sample restarts the average.
module laser_avg_window
  import laser_tracker_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_shift,
  input  logic                 i_clear,
  input  logic [COORD_W-1:0]   i_sample,
  output logic [COORD_W-1:0]   o_avg,
  output logic [COORD_W-1:0]   o_last,
  output logic [AVG_LOG2:0]    o_fill
);

  localparam int unsigned DEPTH  = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = COORD_W + AVG_LOG2;
  localparam int unsigned FILL_W = AVG_LOG2 + 1;

  logic [COORD_W-1:0] r_win [DEPTH];
  logic [SUM_W-1:0]   r_sum;
  logic [FILL_W-1:0]  r_fill;
  logic               w_full;
  logic [COORD_W-1:0] w_evict;

  // Until the window is full the oldest slot holds no real sample.
  assign w_full  = (r_fill == FILL_W'(DEPTH));
  assign w_evict = w_full ? r_win[DEPTH-1] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_win[i] <= '0;
      r_sum  <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < int'(DEPTH); i++) r_win[i] <= '0;
      r_sum  <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_win[0] <= i_sample;
      for (int i = 1; i < int'(DEPTH); i++) r_win[i] <= r_win[i-1];
      r_sum <= r_sum + SUM_W'(i_sample) - SUM_W'(w_evict);
      if (!w_full) r_fill <= r_fill + FILL_W'(1);
    end
  end

  assign o_avg  = COORD_W'(r_sum >> AVG_LOG2);
  assign o_last = r_win[0];
  assign o_fill = r_fill;

endmodule

// File: rtl/laser_tracker.sv
// Per-frame laser tracker: averages detector hits, tracks lock state and hands the
// signed aim error to the turret controller over valid/ready.
module laser_tracker
  import laser_tracker_pkg::*;
#(
  parameter int unsigned AVG_LOG2     = 2,
  parameter int unsigned LOCK_TOL     = 4,
  parameter int unsigned LOCK_FRAMES  = 3,
  parameter int unsigned MISS_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_end,
  input  logic                    laser_valid,
  input  logic [XY_W-1:0]         laser_xy,
  input  logic [XY_W-1:0]         target_xy,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ERR_W-1:0] err_x,
  output logic signed [ERR_W-1:0] err_y,
  output logic [XY_W-1:0]         avg_xy,
  output logic                    locked,
  output logic                    det_rearm,
  output logic                    overrun
);

  localparam int unsigned DEPTH  = 1 << AVG_LOG2;
  localparam int unsigned FILL_W = AVG_LOG2 + 1;
  localparam int unsigned STAB_W = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned MISS_W = $clog2(MISS_TIMEOUT + 1);

  track_state_e       r_state, w_state_nxt;
  logic [STAB_W-1:0]  r_stable, w_stable_nxt;
  logic [MISS_W-1:0]  r_miss, w_miss_nxt;
  logic               r_s1, r_s2, r_locked;
  logic               r_out_valid, r_overrun;
  logic [ERR_W-1:0]   r_err_x, r_err_y;
  logic [XY_W-1:0]    r_avg;

  xy_t                w_smp, w_tgt;
  logic               w_take, w_shift, w_clear, w_full, w_full_after;
  logic               w_in_tol_raw, w_in_tol, w_new_word;
  logic [COORD_W-1:0] w_avg_x, w_avg_y, w_last_x, w_last_y, w_ref_x, w_ref_y;
  logic [FILL_W-1:0]  w_fill_x, w_fill_y;

  assign w_smp   = xy_unpack(laser_xy);
  assign w_tgt   = xy_unpack(target_xy);
  // A frame_end landing while the previous frame is still in flight is dropped.
  assign w_take  = frame_end && !r_s1 && !r_s2;
  assign w_shift = w_take && laser_valid;
  assign w_clear = (w_state_nxt == ST_SEARCH) && (r_state != ST_SEARCH);

  laser_avg_window #(.AVG_LOG2(AVG_LOG2)) u_win_x (
    .clk(clk), .reset(reset), .i_shift(w_shift), .i_clear(w_clear),
    .i_sample(w_smp.x), .o_avg(w_avg_x), .o_last(w_last_x), .o_fill(w_fill_x)
  );

  laser_avg_window #(.AVG_LOG2(AVG_LOG2)) u_win_y (
    .clk(clk), .reset(reset), .i_shift(w_shift), .i_clear(w_clear),
    .i_sample(w_smp.y), .o_avg(w_avg_y), .o_last(w_last_y), .o_fill(w_fill_y)
  );

  assign w_full       = (w_fill_x == FILL_W'(DEPTH)) && (w_fill_y == FILL_W'(DEPTH));
  assign w_full_after = (w_fill_x >= FILL_W'(DEPTH - 1));
  assign w_ref_x      = w_full ? w_avg_x : w_last_x;
  assign w_ref_y      = w_full ? w_avg_y : w_last_y;
  assign w_in_tol_raw = (abs_diff(w_smp.x, w_ref_x) <= (COORD_W + 1)'(LOCK_TOL)) &&
                        (abs_diff(w_smp.y, w_ref_y) <= (COORD_W + 1)'(LOCK_TOL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_SEARCH;
      r_stable <= '0;
      r_miss   <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_stable <= w_stable_nxt;
      r_miss   <= w_miss_nxt;
      r_s1     <= w_take;
      r_s2     <= r_s1;
      r_locked <= (w_state_nxt == ST_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_stable_nxt = r_stable;
    w_miss_nxt   = r_miss;
    w_in_tol     = 1'b0;
    if (w_take && laser_valid) begin
      w_in_tol     = (r_state != ST_SEARCH) && w_in_tol_raw;
      w_miss_nxt   = '0;
      w_stable_nxt = !w_in_tol ? '0 :
                     (r_stable == STAB_W'(LOCK_FRAMES)) ? r_stable : r_stable + STAB_W'(1);
      case (r_state)
        ST_SEARCH:  w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: if (w_full_after && (w_stable_nxt >= STAB_W'(LOCK_FRAMES)))
                      w_state_nxt = ST_LOCKED;
        ST_LOCKED:  if (!w_in_tol) w_state_nxt = ST_ACQUIRE;
        ST_COAST:   w_state_nxt = w_in_tol ? ST_LOCKED : ST_ACQUIRE;
        default:    w_state_nxt = ST_SEARCH;
      endcase
    end else if (w_take) begin
      if (r_miss != MISS_W'(MISS_TIMEOUT)) w_miss_nxt = r_miss + MISS_W'(1);
      case (r_state)
        ST_ACQUIRE, ST_COAST: if (w_miss_nxt == MISS_W'(MISS_TIMEOUT)) w_state_nxt = ST_SEARCH;
        ST_LOCKED:            w_state_nxt = ST_COAST;
        default:              w_state_nxt = r_state;
      endcase
      if (w_state_nxt == ST_SEARCH) w_stable_nxt = '0;
    end
  end

  assign w_new_word = r_s1 && ((r_state == ST_LOCKED) || (r_state == ST_COAST));

  // Output word: a fresh word always wins over an acceptance in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_avg       <= '0;
      r_err_x     <= '0;
      r_err_y     <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_s1) r_avg <= xy_pack(w_avg_x, w_avg_y);
      if (w_new_word) begin
        r_err_x     <= ERR_W'({1'b0, w_tgt.x}) - ERR_W'({1'b0, w_avg_x});
        r_err_y     <= ERR_W'({1'b0, w_tgt.y}) - ERR_W'({1'b0, w_avg_y});
        r_out_valid <= 1'b1;
        r_overrun   <= r_out_valid && !out_ready;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign err_x     = r_err_x;
  assign err_y     = r_err_y;
  assign avg_xy    = r_avg;
  assign locked    = r_locked;
  assign det_rearm = r_s1;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_laser_tracker.sv
// Bench for laser_tracker: directed scenarios then random frames, all checked
// against a queue-based model of the tracking rules.
module tb_laser_tracker;

  localparam int DEPTH = 4;
  localparam int TOL   = 4;
  localparam int LF    = 3;
  localparam int TO    = 8;
  localparam int M_SEARCH = 0, M_ACQ = 1, M_LOCK = 2, M_COAST = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_end = 1'b0;
  logic        laser_valid = 1'b0;
  logic [31:0] laser_xy = '0;
  logic [31:0] target_xy = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, locked, det_rearm, overrun;
  logic [16:0] err_x, err_y;
  logic [31:0] avg_xy;

  always #5 clk = ~clk;

  laser_tracker dut (
    .clk(clk), .reset(reset), .frame_end(frame_end), .laser_valid(laser_valid),
    .laser_xy(laser_xy), .target_xy(target_xy), .out_ready(out_ready),
    .out_valid(out_valid), .err_x(err_x), .err_y(err_y), .avg_xy(avg_xy),
    .locked(locked), .det_rearm(det_rearm), .overrun(overrun)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;

  int mst = M_SEARCH, stable = 0, miss = 0;
  int qx[$], qy[$];
  bit pend = 0, e_word = 0, e_ov = 0, e_lock = 0;
  logic [16:0] e_ex = '0, e_ey = '0;
  logic [31:0] e_avg = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    mst = M_SEARCH; stable = 0; miss = 0;
    qx.delete(); qy.delete();
    pend = 0; e_ex = '0; e_ey = '0; e_avg = '0; e_ov = 0;
  endtask

  task automatic model_frame(input bit v, input int x, input int y);
    int rx, ry, ax, ay;
    bit it = 0;
    if (v) begin
      if (mst != M_SEARCH) begin
        rx = (qx.size() == DEPTH) ? qsum(qx) / DEPTH : qx[$];
        ry = (qy.size() == DEPTH) ? qsum(qy) / DEPTH : qy[$];
        it = (iabs(x - rx) <= TOL) && (iabs(y - ry) <= TOL);
      end
      qx.push_back(x); qy.push_back(y);
      if (qx.size() > DEPTH) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
      end
      miss = 0;
      stable = it ? ((stable < LF) ? stable + 1 : LF) : 0;
      case (mst)
        M_SEARCH: mst = M_ACQ;
        M_ACQ:    if (qx.size() == DEPTH && stable >= LF) mst = M_LOCK;
        M_LOCK:   if (!it) mst = M_ACQ;
        default:  mst = it ? M_LOCK : M_ACQ;
      endcase
    end else begin
      if (miss < TO) miss++;
      if (mst == M_LOCK) mst = M_COAST;
      else if ((mst == M_ACQ || mst == M_COAST) && miss == TO) begin
        mst = M_SEARCH; qx.delete(); qy.delete(); stable = 0;
      end
    end
    ax = qsum(qx) / DEPTH;
    ay = qsum(qy) / DEPTH;
    e_avg  = {16'(ax), 16'(ay)};
    e_lock = (mst == M_LOCK);
    e_word = (mst == M_LOCK) || (mst == M_COAST);
    if (e_word) begin
      e_ex = 17'(int'(target_xy[31:16]) - ax);
      e_ey = 17'(int'(target_xy[15:0]) - ay);
    end
  endtask

  // Advance one clock; word marks the edge at which a new error word is produced.
  task automatic tick(input bit word);
    e_ov = word && pend && !out_ready;
    if (word) pend = 1;
    else if (pend && out_ready) pend = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit v, input int x, input int y, input bit glitch);
    frame_end = 1'b1; laser_valid = v; laser_xy = {16'(x), 16'(y)};
    model_frame(v, x, y);
    tick(0);
    if (glitch) begin
      laser_valid = 1'b1; laser_xy = $urandom;
    end else begin
      frame_end = 1'b0; laser_valid = 1'b0;
    end
    check("rearm_t1", 64'(det_rearm), 64'(1));
    check("locked_t1", 64'(locked), 64'(e_lock));
    tick(e_word);
    check("valid_t2", 64'(out_valid), 64'(pend));
    check("avg_t2", 64'(avg_xy), 64'(e_avg));
    check("errx_t2", 64'(err_x), 64'(e_ex));
    check("erry_t2", 64'(err_y), 64'(e_ey));
    check("overrun_t2", 64'(overrun), 64'(e_ov));
    check("rearm_t2", 64'(det_rearm), 64'(0));
    tick(0);
    frame_end = 1'b0; laser_valid = 1'b0;
    check("rearm_t3", 64'(det_rearm), 64'(0));
    check("overrun_t3", 64'(overrun), 64'(0));
    check("valid_t3", 64'(out_valid), 64'(pend));
    tick(0);
  endtask

  task automatic hard_reset();
    reset = 1'b1; frame_end = 1'b0; laser_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic relock(input int x, input int y);
    hard_reset();
    for (int i = 0; i < 4; i++) frame(1, x, y, 0);
    check("relock", 64'(locked), 64'(1));
  endtask

  int cx, cy;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_avg", 64'(avg_xy), 64'(0));
    check("rst_locked", 64'(locked), 64'(0));

    // Lock on a steady spot, word left pending for the mid-frame reset.
    target_xy = {16'd320, 16'd240};
    out_ready = 1'b0;
    frame(1, 320, 240, 0);
    check("acq_not_locked", 64'(locked), 64'(0));
    for (int i = 0; i < 3; i++) frame(1, 320, 240, 0);
    check("t2_locked", 64'(locked), 64'(1));
    check("t2_valid", 64'(out_valid), 64'(1));
    check("t2_err", 64'({err_x, err_y}), 64'(0));

    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("arst_outs", 64'({out_valid, locked, det_rearm, overrun}), 64'(0));
    check("arst_err", 64'({err_x, err_y}), 64'(0));
    check("arst_avg", 64'(avg_xy), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    out_ready = 1'b1;
    frame(0, 0, 0, 0);
    check("miss_in_search", 64'(out_valid), 64'(0));

    hard_reset();
    target_xy = {16'd110, 16'd60};
    frame(1, 100, 50, 0);
    frame(1, 104, 50, 0);
    frame(1, 100, 50, 0);
    frame(1, 104, 50, 1);
    check("t3_locked", 64'(locked), 64'(1));
    check("t3_avg", 64'(avg_xy), {32'd0, 16'd102, 16'd50});
    check("t3_err", 64'({err_x, err_y}), {30'd0, 17'd8, 17'd10});

    target_xy = {16'd320, 16'd240};
    relock(320, 240);
    frame(1, 400, 240, 0);
    check("t4_unlocked", 64'(locked), 64'(0));
    check("t4_no_word", 64'(out_valid), 64'(0));

    relock(320, 240);
    for (int i = 0; i < 7; i++) frame(0, 0, 0, 0);
    check("t5_coast_err", 64'({err_x, err_y}), 64'(0));
    frame(0, 0, 0, 0);
    check("t5_search_avg", 64'(avg_xy), 64'(0));

    relock(320, 240);
    out_ready = 1'b0;
    frame(1, 321, 239, 0);
    frame(1, 322, 241, 0);
    check("t6_pending", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    tick(0);
    check("t6_dropped", 64'(out_valid), 64'(0));

    // Random frames: jittered spot with occasional jumps, dropouts and back-pressure.
    hard_reset();
    cx = 1000; cy = 2000;
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        cx = int'($urandom_range(20, 65500));
        cy = int'($urandom_range(20, 65500));
      end
      if ($urandom_range(0, 19) == 0)
        target_xy = ($urandom_range(0, 1) == 1) ? 32'hFFFF_0000 : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      frame($urandom_range(0, 6) != 0,
            cx + int'($urandom_range(0, 10)) - 5,
            cy + int'($urandom_range(0, 10)) - 5,
            $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/laser_tracker.md
Name: laser_tracker

Overview:
- Downstream consumer of the laser detector's per-frame `laser_xy` result.
- Samples the detector once per frame at end-of-frame and keeps a sliding-window average of the laser position.
- Decides lock/coast/lost status and produces a signed aim error (target − average) for the turret controller over a valid/ready handshake.
- Pulses a re-arm strobe so the detector restarts its search each frame.

Parameters:
- `COORD_W`, 16: width of each coordinate; `xy` buses are {x, y}, 2*COORD_W wide, x in the upper half.
- `AVG_LOG2`, 2: window depth = 2^AVG_LOG2 samples.
- `LOCK_TOL`, 4: maximum per-axis |sample − avg| that counts as stable.
- `LOCK_FRAMES`, 3: consecutive stable samples needed for lock.
- `MISS_TIMEOUT`, 8: consecutive frames with no laser before the track is dropped.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `frame_end` in 1: one-cycle pulse after the last pixel of a frame.
- `laser_valid` in 1: detector found a laser this frame.
- `laser_xy` in 32: detector position {x, y}.
- `target_xy` in 32: aim point {x, y}, quasi-static.
- `out_ready` in 1: consumer accepts the error word.
- `out_valid` out 1: error word pending.
- `err_x` out 17: signed target_x − avg_x.
- `err_y` out 17: signed target_y − avg_y.
- `avg_xy` out 32: current averaged position.
- `locked` out 1: high in LOCKED state.
- `det_rearm` out 1: one-cycle pulse to restart the detector.
- `overrun` out 1: one-cycle pulse when an unaccepted word is overwritten.

Behaviour:
- Reset (asynchronous) clears all registers. Every output is 0; state is SEARCH; fill, stable_cnt and miss_cnt are 0.
- Pipeline, with frame_end sampled at cycle T:
  - T+1: tolerance compare, window/sum update, counter and state update; `det_rearm` = 1 for this cycle only.
  - T+2: `avg_xy`, `err_x`/`err_y` registered. `out_valid` set if the new state is LOCKED or COAST.
- A frame_end arriving at T+1 or T+2 is ignored.
- Reference position (ref):
  - `avg_xy` before the update: sum >> AVG_LOG2 when fill == depth.
  - Otherwise the most recent accepted sample.
- Valid sample (`laser_valid` = 1 at frame_end):
  - Shift into the per-axis window; running sum += new − evicted (evicted counts as 0 while not full).
  - fill saturates at depth; miss_cnt ← 0.
  - in_tol = (|x − ref_x| ≤ LOCK_TOL) && (|y − ref_y| ≤ LOCK_TOL). Absolute differences are computed on COORD_W+1 bits, unsigned coordinates.
  - in_tol → stable_cnt++ (saturating). Otherwise stable_cnt ← 0.
  - In SEARCH, ref is not defined: in_tol is forced 0 and stable_cnt ← 0.
- Missing sample: miss_cnt++ (saturating); window untouched.
- States:
  - SEARCH:
    - valid → ACQUIRE (fill = 1).
    - miss → stay.
  - ACQUIRE:
    - valid, fill == depth after the update and stable_cnt ≥ LOCK_FRAMES → LOCKED.
    - miss with miss_cnt reaching MISS_TIMEOUT → SEARCH.
  - LOCKED:
    - valid && !in_tol → ACQUIRE; stable_cnt ← 0, window kept.
    - miss → COAST.
  - COAST:
    - valid && in_tol → LOCKED.
    - valid && !in_tol → ACQUIRE.
    - miss_cnt reaching MISS_TIMEOUT → SEARCH.
  - Entry to SEARCH clears the window, sum, fill and stable_cnt, and sets `avg_xy` = 0.
- Error arithmetic: err = {1'b0, target} − {1'b0, avg}, signed 17-bit, no saturation.
- Handshake:
  - `out_valid` holds with stable data until `out_valid && out_ready`, then drops the next cycle.
  - If a new word is produced while the previous one is unaccepted, it overwrites the old word, `overrun` pulses and `out_valid` stays high.
  - If acceptance and a new word occur in the same cycle, the new word loads and there is no overrun.
  - A transition to ACQUIRE/SEARCH does not retract a pending word.

Decomposition:
- Shared package holds:
  - state encoding (SEARCH, ACQUIRE, LOCKED, COAST);
  - COORD_W, with xy pack/unpack functions (x = upper half);
  - the signed error width.
- Sub-module `laser_avg_window`:
  - one axis: 2^AVG_LOG2-deep shift register, running sum of COORD_W+AVG_LOG2 bits, fill counter, clear input, avg output.
  - Instantiated twice (x, y).

Test Plan:
1. Reset asserted mid-frame with `out_valid` = 1 → all outputs 0 immediately (asynchronous); after release, state is SEARCH and the first frame_end with laser_valid = 0 produces no `out_valid`.
2. Four frames at (320,240), target (320,240) → ACQUIRE after frame 1, `locked` = 1 after frame 4; `out_valid` 2 cycles after frame 4's frame_end with err = (0,0); `det_rearm` pulse at T+1 each frame.
3. x samples 100, 104, 100, 104 (y = 50), target (110,60) → lock at frame 4; `avg_xy` = (102,50); err = (+8,+10).
4. While locked at (320,240), sample (400,240) → `locked` falls at T+1; state ACQUIRE; no new `out_valid`.
5. Locked, then 8 frames with `laser_valid` = 0 → frames 1–7: COAST, `out_valid` each frame with unchanged err; frame 8: SEARCH, `avg_xy` = 0, no word.
6. Locked with `out_ready` held 0 across two frames → second word overwrites the first and `overrun` pulses once; raising `out_ready` accepts the second word and `out_valid` drops the next cycle.
